// File: rtl/if_fetch_pkg.sv
// Shared constants for the IF stage: bus widths, reset PC
// and FSM state encodings.
package if_fetch_pkg;

    localparam logic [31:0] RESET_PC    = 32'hBFC0_0000;
    localparam int          IF_TO_ID_WD = 33;
    localparam int          BR_WD       = 33;
    localparam int          STALL_W     = 6;

    localparam logic        STOP   = 1'b1;
    localparam logic        NOSTOP = 1'b0;

    localparam logic [1:0]  S_IDLE = 2'd0;
    localparam logic [1:0]  S_RUN  = 2'd1;
    localparam logic [1:0]  S_HOLD = 2'd2;
    localparam logic [1:0]  S_PEND = 2'd3;

endpackage

// File: rtl/if_fetch_if.sv
// IF stage link bundle: stall/branch inputs, IF->ID bus,
// instruction SRAM request port and debug state.
import if_fetch_pkg::*;

interface if_fetch_if;

    logic [STALL_W-1:0]     stall;
    logic [BR_WD-1:0]       br_bus;
    logic [IF_TO_ID_WD-1:0] if_to_id_bus;
    logic                   inst_sram_en;
    logic [3:0]             inst_sram_wen;
    logic [31:0]            inst_sram_addr;
    logic [31:0]            inst_sram_wdata;
    logic [1:0]             if_state;

    modport master (
        input  stall,
        input  br_bus,
        output if_to_id_bus,
        output inst_sram_en,
        output inst_sram_wen,
        output inst_sram_addr,
        output inst_sram_wdata,
        output if_state
    );

    modport slave (
        output stall,
        output br_bus,
        input  if_to_id_bus,
        input  inst_sram_en,
        input  inst_sram_wen,
        input  inst_sram_addr,
        input  inst_sram_wdata,
        input  if_state
    );

endinterface

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, issues SRAM fetches and
// holds any branch redirect that arrives while the PC is stalled.
import if_fetch_pkg::*;

module if_fetch (
    input  logic           clk,
    input  logic           rst,
    if_fetch_if.master     bus
);

    logic        r_ce;
    logic [31:0] r_pc;
    logic        r_pend_v;
    logic [31:0] r_pend_addr;
    logic [1:0]  r_state;

    logic        w_br_e;
    logic [31:0] w_br_addr;
    logic        w_stop;
    logic [31:0] w_pc_inc;
    logic [31:0] w_next_pc;

    assign w_br_e    = bus.br_bus[32];
    assign w_br_addr = bus.br_bus[31:0];
    assign w_stop    = bus.stall[0];
    assign w_pc_inc  = r_pc + 32'd4;

    // Redirect priority: live branch, then latched branch, then sequential.
    always_comb begin
        w_next_pc = w_pc_inc;
        if (w_br_e)
            w_next_pc = w_br_addr;
        else if (r_pend_v)
            w_next_pc = r_pend_addr;
    end

    // PC / pending-redirect state machine.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ce        <= 1'b0;
            r_pc        <= RESET_PC - 32'd4;
            r_pend_v    <= 1'b0;
            r_pend_addr <= 32'd0;
            r_state     <= S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    // Branches and stalls are not meaningful before the first fetch.
                    r_ce    <= 1'b1;
                    r_pc    <= w_pc_inc;
                    r_state <= S_RUN;
                end
                S_RUN, S_HOLD: begin
                    if (w_stop == NOSTOP) begin
                        r_pc    <= w_next_pc;
                        r_state <= S_RUN;
                    end else if (w_br_e) begin
                        r_pend_v    <= 1'b1;
                        r_pend_addr <= w_br_addr;
                        r_state     <= S_PEND;
                    end else begin
                        r_state <= S_HOLD;
                    end
                end
                S_PEND: begin
                    if (w_stop == NOSTOP) begin
                        r_pc     <= w_next_pc;
                        r_pend_v <= 1'b0;
                        r_state  <= S_RUN;
                    end else if (w_br_e) begin
                        r_pend_addr <= w_br_addr;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.if_to_id_bus    = {r_ce, r_pc};
    assign bus.inst_sram_en    = r_ce;
    assign bus.inst_sram_wen   = 4'b0000;
    assign bus.inst_sram_addr  = r_pc;
    assign bus.inst_sram_wdata = 32'd0;
    assign bus.if_state        = r_state;

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: table of per-cycle vectors
// with a scoreboard queue, plus hand-written async-reset sequence.
import if_fetch_pkg::*;

module tb_if_fetch;

    logic clk;
    logic rst;

    if_fetch_if bus ();

    if_fetch dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  stall;
        logic        br_e;
        logic [31:0] br_addr;
        logic [31:0] exp_addr;
        logic        exp_en;
        logic [1:0]  exp_state;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic        en;
        logic [1:0]  state;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_vec;
    int   n_bad;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic chk_out(input string tag, input exp_t e);
        chk({tag, " addr"}, bus.inst_sram_addr, e.addr);
        chk({tag, " en"}, {31'd0, bus.inst_sram_en}, {31'd0, e.en});
        chk({tag, " state"}, {30'd0, bus.if_state}, {30'd0, e.state});
        chk({tag, " bus"}, bus.if_to_id_bus[31:0], e.addr);
        chk({tag, " ce"}, {31'd0, bus.if_to_id_bus[32]}, {31'd0, e.en});
        chk({tag, " wen"}, {28'd0, bus.inst_sram_wen}, 32'd0);
        chk({tag, " wdata"}, bus.inst_sram_wdata, 32'd0);
    endtask

    task automatic step(input string tag, input logic [5:0] st,
                        input logic be, input logic [31:0] ba,
                        input logic [31:0] ea, input logic ee,
                        input logic [1:0] es);
        exp_t e;
        e.addr  = ea;
        e.en    = ee;
        e.state = es;
        sb.push_back(e);
        bus.stall  = st;
        bus.br_bus = {be, ba};
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            chk_out(tag, sb.pop_front());
        end
    endtask

    function automatic vec_t mk(input logic [5:0] st, input logic be,
                                input logic [31:0] ba,
                                input logic [31:0] ea,
                                input logic [1:0] es);
        vec_t v;
        v.stall     = st;
        v.br_e      = be;
        v.br_addr   = ba;
        v.exp_addr  = ea;
        v.exp_en    = 1'b1;
        v.exp_state = es;
        return v;
    endfunction

    exp_t rst_exp;

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst_exp.addr  = RESET_PC - 32'd4;
        rst_exp.en    = 1'b0;
        rst_exp.state = S_IDLE;

        // IDLE ignores stall and branch
        vecs.push_back(mk(6'b000011, 1'b1, 32'hDEADBEEF, 32'hBFC00000, S_RUN));
        vecs.push_back(mk(6'd0, 1'b0, 32'h0, 32'hBFC00004, S_RUN));
        vecs.push_back(mk(6'd0, 1'b0, 32'h0, 32'hBFC00008, S_RUN));
        // branch
        vecs.push_back(mk(6'd0, 1'b1, 32'hBFC00040, 32'hBFC00040, S_RUN));
        vecs.push_back(mk(6'd0, 1'b0, 32'h0, 32'hBFC00044, S_RUN));
        vecs.push_back(mk(6'd0, 1'b1, 32'hBFC0000C, 32'hBFC0000C, S_RUN));
        vecs.push_back(mk(6'd0, 1'b0, 32'h0, 32'hBFC00010, S_RUN));
        // stall 3 clk
        vecs.push_back(mk(6'b000011, 1'b0, 32'h0, 32'hBFC00010, S_HOLD));
        vecs.push_back(mk(6'b000011, 1'b0, 32'h0, 32'hBFC00010, S_HOLD));
        vecs.push_back(mk(6'b000011, 1'b0, 32'h0, 32'hBFC00010, S_HOLD));
        vecs.push_back(mk(6'd0, 1'b0, 32'h0, 32'hBFC00014, S_RUN));
        // pend from HOLD
        vecs.push_back(mk(6'b000011, 1'b0, 32'h0, 32'hBFC00014, S_HOLD));
        vecs.push_back(mk(6'b000011, 1'b1, 32'hBFC00100, 32'hBFC00014, S_PEND));
        vecs.push_back(mk(6'b000011, 1'b0, 32'h0, 32'hBFC00014, S_PEND));
        vecs.push_back(mk(6'd0, 1'b0, 32'h0, 32'hBFC00100, S_RUN));
        vecs.push_back(mk(6'd0, 1'b0, 32'h0, 32'hBFC00104, S_RUN));
        // pend from RUN, live branch wins on release
        vecs.push_back(mk(6'b000011, 1'b1, 32'hBFC00100, 32'hBFC00104, S_PEND));
        vecs.push_back(mk(6'b000011, 1'b1, 32'hBFC00180, 32'hBFC00104, S_PEND));
        vecs.push_back(mk(6'd0, 1'b1, 32'hBFC00200, 32'hBFC00200, S_RUN));
        vecs.push_back(mk(6'd0, 1'b0, 32'h0, 32'hBFC00204, S_RUN));
        // newer branch overwrites pend
        vecs.push_back(mk(6'b000011, 1'b1, 32'hBFC00300, 32'hBFC00204, S_PEND));
        vecs.push_back(mk(6'b000011, 1'b1, 32'hBFC00340, 32'hBFC00204, S_PEND));
        vecs.push_back(mk(6'd0, 1'b0, 32'h0, 32'hBFC00340, S_RUN));
        vecs.push_back(mk(6'd0, 1'b0, 32'h0, 32'hBFC00344, S_RUN));
        // misaligned target passes through
        vecs.push_back(mk(6'd0, 1'b1, 32'hBFC00402, 32'hBFC00402, S_RUN));
        vecs.push_back(mk(6'd0, 1'b0, 32'h0, 32'hBFC00406, S_RUN));
        // wrap at 2^32
        vecs.push_back(mk(6'd0, 1'b1, 32'hFFFFFFFC, 32'hFFFFFFFC, S_RUN));
        vecs.push_back(mk(6'd0, 1'b0, 32'h0, 32'h00000000, S_RUN));
        // release from HOLD with live branch; only stall[0] matters
        vecs.push_back(mk(6'b000001, 1'b0, 32'h0, 32'h00000000, S_HOLD));
        vecs.push_back(mk(6'b000010, 1'b1, 32'hBFC00500, 32'hBFC00500, S_RUN));
        vecs.push_back(mk(6'd0, 1'b0, 32'h0, 32'hBFC00504, S_RUN));

        rst        = 1'b1;
        bus.stall  = 6'd0;
        bus.br_bus = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_out("reset", rst_exp);

        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_out("release", rst_exp);

        foreach (vecs[i]) begin
            step($sformatf("v%0d", i), vecs[i].stall, vecs[i].br_e,
                 vecs[i].br_addr, vecs[i].exp_addr, vecs[i].exp_en,
                 vecs[i].exp_state);
        end

        // async reset mid-PEND, between edges
        step("t6 pend", 6'b000011, 1'b1, 32'hBFC00600,
             32'hBFC00504, 1'b1, S_PEND);
        bus.br_bus = '0;
        #2;
        rst = 1'b1;
        #1;
        chk_out("t6 async", rst_exp);
        @(posedge clk);
        #1;
        chk_out("t6 held", rst_exp);
        #1;
        rst = 1'b0;
        step("t6 r0", 6'b000011, 1'b0, 32'h0, 32'hBFC00000, 1'b1, S_RUN);
        step("t6 r1", 6'd0, 1'b0, 32'h0, 32'hBFC00004, 1'b1, S_RUN);
        step("t6 r2", 6'd0, 1'b0, 32'h0, 32'hBFC00008, 1'b1, S_RUN);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
